control_sequencer: RTL and testbench

- Multi-cycle control FSM for the LITE-16 core.
- Fetches each instruction over a memory handshake and decodes opcode bits 0-3.
- Sequences the register fetch unit and register file by driving ri/st/jmp/fn, the register write enable, the PC and the memory strobes.
- Also provides a memory-timeout fault and a retired-instruction counter.

---
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the LITE-16 core: fetch/decode/execute FSM
// with registered control strobes, a memory-wait timeout fault and a retire counter.
module control_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       i0_3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ri,
  output logic             st,
  output logic             jmp,
  output logic             fn,
  output logic             reg_we,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic ir_we;
    logic pc_inc;
    logic pc_load;
    logic ri;
    logic st;
    logic jmp;
    logic fn;
    logic reg_we;
    logic busy;
    logic fault;
  } ctl_t;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  // Last wait count that may still be followed by another unanswered cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctl_t             ctl_q, ctl_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state_q == S_FETCH)   state_d = S_DECODE;
          else if (op_q == OP_ST)   state_d = S_FETCH;
          else                      state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = i0_3;
        case (i0_3)
          4'h0, 4'hC, 4'hD, 4'hE: state_d = S_FETCH;
          OP_HALT:                state_d = S_HALT;
          default:                state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (op_q == OP_LD || op_q == OP_ST) state_d = S_MEM;
        else if (op_q == OP_JMP)            state_d = S_FETCH;
        else                                state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // An instruction retires when it leaves its final state back to FETCH or into HALT.
  assign retire  = (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) &&
                   (state_d inside {S_FETCH, S_HALT});
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH:  begin ctl_d.mem_req = 1'b1; ctl_d.busy = 1'b1; end
      S_DECODE: begin ctl_d.ir_we = 1'b1; ctl_d.pc_inc = 1'b1; ctl_d.busy = 1'b1; end
      S_EXEC:   begin ctl_d.busy = 1'b1; ctl_d.pc_load = (op_d == OP_JMP); end
      S_MEM:    begin ctl_d.mem_req = 1'b1; ctl_d.busy = 1'b1; ctl_d.mem_we = (op_d == OP_ST); end
      S_WB:     begin ctl_d.reg_we = 1'b1; ctl_d.busy = 1'b1; end
      S_FAULT:  ctl_d.fault = 1'b1;
      default:  ctl_d = '0;
    endcase
    if (state_d inside {S_EXEC, S_MEM, S_WB}) begin
      ctl_d.fn  = (op_d >= 4'h1) && (op_d <= 4'h7);
      ctl_d.ri  = (op_d == OP_LDI);
      ctl_d.st  = (op_d == OP_ST);
      ctl_d.jmp = (op_d == OP_JMP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      count_q <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      ctl_q   <= ctl_d;
    end
  end

  assign mem_req     = ctl_q.mem_req;
  assign mem_we      = ctl_q.mem_we;
  assign ir_we       = ctl_q.ir_we;
  assign pc_inc      = ctl_q.pc_inc;
  assign pc_load     = ctl_q.pc_load;
  assign ri          = ctl_q.ri;
  assign st          = ctl_q.st;
  assign jmp         = ctl_q.jmp;
  assign fn          = ctl_q.fn;
  assign reg_we      = ctl_q.reg_we;
  assign busy        = ctl_q.busy;
  assign fault       = ctl_q.fault;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction trace generator builds the
// expected output sequence, and each cycle the DUT outputs are compared against it.
module tb_control_sequencer;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic             clk, rst, start, mem_ready;
  logic [3:0]       i0_3;
  logic             mem_req, mem_we, ir_we, pc_inc, pc_load;
  logic             ri, st, jmp, fn, reg_we, busy, fault;
  logic [CNT_W-1:0] instr_count;

  control_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .i0_3(i0_3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_inc(pc_inc),
    .pc_load(pc_load), .ri(ri), .st(st), .jmp(jmp), .fn(fn), .reg_we(reg_we),
    .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_we, ir_we, pc_inc, pc_load, ri, st, jmp, fn, reg_we, busy, fault;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       rdy;
    logic [3:0] op;
    exp_t       e;
  } cyc_t;

  cyc_t       sched[$];
  int         m_cnt;
  bit         m_fault;
  bit         start_in_wait;
  logic [3:0] junk_op;
  int         n_pass, n_total, cyc_no;

  function automatic exp_t base();
    exp_t e;
    e       = '0;
    e.fault = m_fault;
    e.cnt   = m_cnt[CNT_W-1:0];
    return e;
  endfunction

  task automatic push(input logic st_, input logic rdy_, input logic [3:0] op_, input exp_t e);
    cyc_t r;
    r.rst_n = 1'b1; r.start = st_; r.rdy = rdy_; r.op = op_; r.e = e;
    sched.push_back(r);
  endtask

  task automatic push_rst(input int n);
    cyc_t r;
    r.rst_n = 1'b0; r.start = 1'b0; r.rdy = 1'b0; r.op = junk_op; r.e = '0;
    for (int i = 0; i < n; i++) sched.push_back(r);
  endtask

  // Idle/halt/fault cycles; mem_ready is held high to show it is ignored there.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, junk_op, base());
  endtask

  task automatic go();
    push(1'b1, 1'b0, junk_op, base());
    m_fault = 1'b0;
  endtask

  // d unanswered request cycles then an ack; d >= TIMEOUT ends in FAULT instead.
  task automatic wait_phase(input int d, input exp_t e, input logic [3:0] ack_op, output bit to);
    to = 1'b0;
    if (d >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) push(start_in_wait, 1'b0, junk_op, e);
      m_fault = 1'b1;
      to = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) push(start_in_wait, 1'b0, junk_op, e);
      push(start_in_wait, 1'b1, ack_op, e);
    end
  endtask

  task automatic instr(input logic [3:0] op, input int fd, input int md);
    exp_t e, em;
    bit   to;
    e = base(); e.mem_req = 1'b1; e.busy = 1'b1;
    wait_phase(fd, e, op, to);
    if (to) return;
    e = base(); e.ir_we = 1'b1; e.pc_inc = 1'b1; e.busy = 1'b1;
    push(1'b0, 1'b1, op, e);
    junk_op = ~op;
    if (op == 4'h0 || op >= 4'hC) begin
      m_cnt++;
      return;
    end
    e = base(); e.busy = 1'b1;
    e.fn  = (op >= 4'h1 && op <= 4'h7);
    e.ri  = (op == 4'h8);
    e.st  = (op == 4'hA);
    e.jmp = (op == 4'hB);
    em = e;
    if (op == 4'hB) e.pc_load = 1'b1;
    push(1'b0, 1'b1, junk_op, e);
    if (op == 4'hB) begin
      m_cnt++;
      return;
    end
    if (op == 4'h9 || op == 4'hA) begin
      em.mem_req = 1'b1;
      em.mem_we  = (op == 4'hA);
      wait_phase(md, em, junk_op, to);
      if (to) return;
      if (op == 4'hA) begin
        m_cnt++;
        return;
      end
    end
    em.mem_req = 1'b0; em.mem_we = 1'b0; em.reg_we = 1'b1;
    push(1'b0, 1'b1, junk_op, em);
    m_cnt++;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  task automatic run_sched();
    cyc_t r;
    exp_t g;
    while (sched.size() > 0) begin
      r = sched.pop_front();
      @(posedge clk); #1;
      rst = r.rst_n; start = r.start; mem_ready = r.rdy; i0_3 = r.op;
      @(negedge clk);
      cyc_no++;
      g = {mem_req, mem_we, ir_we, pc_inc, pc_load, ri, st, jmp, fn, reg_we, busy, fault, instr_count};
      n_total++;
      if (g == r.e) n_pass++;
      else $display("FAIL cycle_cmp cyc=%0d got={req,we,ir,inc,ld,ri,st,jmp,fn,rwe,busy,flt}=%b cnt=%0d expected=%b cnt=%0d",
                    cyc_no, g[15:4], g.cnt, r.e[15:4], r.e.cnt);
    end
  endtask

  logic [3:0] nop_ops [4];

  initial begin
    rst = 1'b0; start = 1'b0; mem_ready = 1'b0; i0_3 = 4'h0;
    m_cnt = 0; m_fault = 1'b0; start_in_wait = 1'b0; junk_op = 4'h5;
    n_pass = 0; n_total = 0; cyc_no = 0;
    nop_ops[0] = 4'h0; nop_ops[1] = 4'hC; nop_ops[2] = 4'hD; nop_ops[3] = 4'hE;

    push_rst(3); idle(3); run_sched();

    go(); instr(4'h3, 0, 0); instr(4'hF, 0, 0); idle(2); run_sched();
    check("alu_halt_count", int'(instr_count), 2);

    go();
    start_in_wait = 1'b1; instr(4'h9, 3, 3); start_in_wait = 1'b0;
    instr(4'hA, 3, 3); instr(4'h8, 0, 0); instr(4'hF, 0, 0); idle(2); run_sched();
    check("ld_st_count", int'(instr_count), 6);

    go(); instr(4'hB, 0, 0); instr(4'h7, 1, 0); instr(4'hF, 2, 0); idle(2); run_sched();
    check("jmp_halt_count", int'(instr_count), 9);
    check("halt_busy", int'(busy), 0);

    go();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e = base(); e.mem_req = 1'b1; e.busy = 1'b1;
      push(1'b0, 1'b0, junk_op, e);
    end
    run_sched();
    #2;
    check("pre_reset_mem_req", int'(mem_req), 1);
    rst = 1'b0;
    #1;
    check("async_reset_mem_req", int'(mem_req), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_count", int'(instr_count), 0);
    m_cnt = 0; m_fault = 1'b0;
    push_rst(2); idle(3); run_sched();

    go();
    for (int i = 0; i < 17; i++) instr(nop_ops[i % 4], 0, 0);
    instr(4'h0, 15, 0);
    idle(2); run_sched();
    check("wrap_count", int'(instr_count), 1);
    check("fetch_timeout_fault", int'(fault), 1);

    go(); instr(4'h0, 14, 0); instr(4'h9, 0, 15); idle(2); run_sched();
    check("mem_timeout_fault", int'(fault), 1);
    check("mem_timeout_count", int'(instr_count), 2);

    go(); instr(4'hA, 0, 14); instr(4'hF, 0, 0); idle(2); run_sched();
    check("fault_cleared", int'(fault), 0);
    check("final_count", int'(instr_count), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
